// File: rtl/cond_unit.sv
// rtl/cond_unit.sv - NZCV flag register, condition evaluation and write-enable gating stage
module cond_unit #(
  parameter logic [3:0] RESET_FLAGS = 4'b0000,
  parameter bit         NV_IS_AL    = 1'b0,
  parameter int         CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       Cond,
  input  logic [1:0]       FlagW,
  input  logic [3:0]       ALUFlags,
  input  logic             PCS,
  input  logic             RegW,
  input  logic             MemW,
  input  logic             NoWrite,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             PCSrc,
  output logic             RegWrite,
  output logic             MemWrite,
  output logic             CondEx,
  output logic [3:0]       Flags,
  output logic [CNT_W-1:0] fail_cnt
);

  logic n_f, z_f, c_f, v_f;
  logic cond_ok;
  logic accept;

  assign {n_f, z_f, c_f, v_f} = Flags;
  assign in_ready = ~out_valid | out_ready;
  assign accept   = in_valid & in_ready & ~flush;

  // Evaluated against the flags as they stand before this instruction commits.
  always_comb begin
    cond_ok = 1'b0;
    case (Cond)
      4'b0000: cond_ok = z_f;
      4'b0001: cond_ok = ~z_f;
      4'b0010: cond_ok = c_f;
      4'b0011: cond_ok = ~c_f;
      4'b0100: cond_ok = n_f;
      4'b0101: cond_ok = ~n_f;
      4'b0110: cond_ok = v_f;
      4'b0111: cond_ok = ~v_f;
      4'b1000: cond_ok = c_f & ~z_f;
      4'b1001: cond_ok = ~c_f | z_f;
      4'b1010: cond_ok = (n_f == v_f);
      4'b1011: cond_ok = (n_f != v_f);
      4'b1100: cond_ok = ~z_f & (n_f == v_f);
      4'b1101: cond_ok = z_f | (n_f != v_f);
      4'b1110: cond_ok = 1'b1;
      default: cond_ok = NV_IS_AL;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      PCSrc     <= 1'b0;
      RegWrite  <= 1'b0;
      MemWrite  <= 1'b0;
      CondEx    <= 1'b0;
      Flags     <= RESET_FLAGS;
      fail_cnt  <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
      PCSrc     <= 1'b0;
      RegWrite  <= 1'b0;
      MemWrite  <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      PCSrc     <= PCS & cond_ok;
      RegWrite  <= RegW & cond_ok & ~NoWrite;
      MemWrite  <= MemW & cond_ok;
      CondEx    <= cond_ok;
      if (cond_ok && FlagW[1]) Flags[3:2] <= ALUFlags[3:2];
      if (cond_ok && FlagW[0]) Flags[1:0] <= ALUFlags[1:0];
      if (!cond_ok && fail_cnt != {CNT_W{1'b1}})
        fail_cnt <= fail_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
